// File: rtl/nunchuck_i2c_target_if.sv
`default_nettype none
// ============================================================================
//  Module      : nunchuck_i2c_target_if
//  Description : Open-drain I2C pin pair (SCL/SDA). The interface resolves the
//                wired-AND SDA level from the initiator and target pull-downs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nunchuck_i2c_target_if;
    logic scl;       // clock driven by the initiator
    logic sda_init;  // initiator SDA level, 1 = released
    logic sda_oe;    // target pull-down, 1 = drive 0, 0 = high-Z
    logic sda;       // resolved bus level

    assign sda = sda_init & ~sda_oe;

    modport master (output scl, output sda_init, input sda);
    modport slave  (input scl, input sda, output sda_oe);
endinterface
`default_nettype wire

// File: rtl/nunchuck_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : nunchuck_i2c_target
//  Description : I2C target emulating a Wii Nunchuck (6-byte report, init
//                registers 0xF0/0xFB). Optional macro NUNCHUCK_TGT_INIT_CHECK_EN
//                NACKs read addressing until the init sequence is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module nunchuck_i2c_target #(
    parameter logic [6:0] ADDR = 7'h52,
    parameter int         FILT = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    nunchuck_i2c_target_if.slave   bus,
    input  wire logic [7:0]        joy_x,
    input  wire logic [7:0]        joy_y,
    input  wire logic [9:0]        acc_x,
    input  wire logic [9:0]        acc_y,
    input  wire logic [9:0]        acc_z,
    input  wire logic              btn_c,
    input  wire logic              btn_z,
    output logic                   init_done,
    output logic [7:0]             rd_count,
    output logic                   busy
);

    localparam int c_CNT_W = (FILT > 1) ? $clog2(FILT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    // ---------------- pin synchronizer and glitch filter --------------------
    logic [1:0] r_sync1, r_sync2, r_filt_q, w_filt;   // bit 1 = SCL, bit 0 = SDA

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt_q <= 2'b11;
        end else begin
            r_sync1  <= {bus.scl, bus.sda};
            r_sync2  <= r_sync1;
            r_filt_q <= w_filt;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_lvl;
            // New level accepted only after FILT consecutive differing samples
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_lvl <= 1'b1;
                end else if (r_sync2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_W'(FILT - 1)) begin
                    r_cnt <= '0;
                    r_lvl <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_sda      = w_filt[0];
    assign w_scl_rise =  w_filt[1] & ~r_filt_q[1];
    assign w_scl_fall = ~w_filt[1] &  r_filt_q[1];
    assign w_start    =  r_filt_q[0] & ~w_filt[0] & w_filt[1] & r_filt_q[1];
    assign w_stop     = ~r_filt_q[0] &  w_filt[0] & w_filt[1] & r_filt_q[1];

    // ---------------- state and datapath registers ---------------------------
    state_t          r_state,     w_state_nxt;
    logic [3:0]      r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0]      r_shift,     w_shift_nxt;
    logic [7:0]      r_tx,        w_tx_nxt;
    logic [7:0]      r_ptr,       w_ptr_nxt;
    logic [7:0]      r_reg_f0,    w_reg_f0_nxt;
    logic [7:0]      r_rd_count,  w_rd_count_nxt;
    logic            r_sda_oe,    w_sda_oe_nxt;
    logic            r_rw,        w_rw_nxt;
    logic            r_first,     w_first_nxt;
    logic            r_init_done, w_init_done_nxt;
    logic [5:0][7:0] r_frame,     w_frame_nxt;
    logic            r_busy;

    logic [5:0][7:0] w_snap;
    logic [7:0]      w_rd_byte;
    logic            w_rd_allowed;

    assign w_snap = {{acc_z[1:0], acc_y[1:0], acc_x[1:0], ~btn_c, ~btn_z},
                     acc_z[9:2], acc_y[9:2], acc_x[9:2], joy_y, joy_x};

`ifdef NUNCHUCK_TGT_INIT_CHECK_EN
    assign w_rd_allowed = r_init_done;
`else
    assign w_rd_allowed = 1'b1;
`endif

    always_comb begin
        w_rd_byte = 8'hFF;
        case (r_ptr)
            8'd0:    w_rd_byte = r_frame[0];
            8'd1:    w_rd_byte = r_frame[1];
            8'd2:    w_rd_byte = r_frame[2];
            8'd3:    w_rd_byte = r_frame[3];
            8'd4:    w_rd_byte = r_frame[4];
            8'd5:    w_rd_byte = r_frame[5];
            default: w_rd_byte = 8'hFF;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_tx_nxt        = r_tx;
        w_ptr_nxt       = r_ptr;
        w_reg_f0_nxt    = r_reg_f0;
        w_rd_count_nxt  = r_rd_count;
        w_sda_oe_nxt    = r_sda_oe;
        w_rw_nxt        = r_rw;
        w_first_nxt     = r_first;
        w_init_done_nxt = r_init_done;
        w_frame_nxt     = r_frame;

        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
        end else if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_rw_nxt = r_shift[0];
                        if (r_shift[7:1] == ADDR && (!r_shift[0] || w_rd_allowed)) begin
                            w_state_nxt  = S_ADDR_ACK;
                            w_sda_oe_nxt = 1'b1;
                            w_first_nxt  = 1'b1;
                            if (r_shift[0])
                                w_frame_nxt = w_snap;
                        end else begin
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_rw) begin
                            w_state_nxt  = S_RD_DATA;
                            w_tx_nxt     = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                            w_ptr_nxt    = r_ptr + 8'd1;
                        end else begin
                            w_state_nxt  = S_WR_DATA;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        w_state_nxt  = S_WR_ACK;
                        w_sda_oe_nxt = 1'b1;
                        w_first_nxt  = 1'b0;
                        if (r_first) begin
                            w_ptr_nxt = r_shift;
                        end else begin
                            if (r_ptr == 8'hF0)
                                w_reg_f0_nxt = r_shift;
                            // Init completes once 0x00 lands in 0xFB after 0x55 in 0xF0
                            if (r_ptr == 8'hFB && r_shift == 8'h00 && r_reg_f0 == 8'h55)
                                w_init_done_nxt = 1'b1;
                            w_ptr_nxt = r_ptr + 8'd1;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = S_WR_DATA;
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_state_nxt  = S_RD_ACK;
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_sda_oe_nxt = ~r_tx[6];
                            w_tx_nxt     = {r_tx[6:0], 1'b0};
                        end
                    end
                end
                S_RD_ACK: begin
                    // A fall here means the initiator ACKed on the preceding rise
                    if (w_scl_rise && w_sda) begin
                        w_state_nxt    = S_WAIT_STOP;
                        w_rd_count_nxt = r_rd_count + 8'd1;
                    end else if (w_scl_fall) begin
                        w_state_nxt   = S_RD_DATA;
                        w_bit_cnt_nxt = 4'd0;
                        w_tx_nxt      = w_rd_byte;
                        w_sda_oe_nxt  = ~w_rd_byte[7];
                        w_ptr_nxt     = r_ptr + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_ptr       <= 8'h00;
            r_reg_f0    <= 8'h00;
            r_rd_count  <= 8'h00;
            r_sda_oe    <= 1'b0;
            r_rw        <= 1'b0;
            r_first     <= 1'b0;
            r_init_done <= 1'b0;
            r_frame     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_tx        <= w_tx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_reg_f0    <= w_reg_f0_nxt;
            r_rd_count  <= w_rd_count_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_rw        <= w_rw_nxt;
            r_first     <= w_first_nxt;
            r_init_done <= w_init_done_nxt;
            r_frame     <= w_frame_nxt;
            if (w_stop)
                r_busy <= 1'b0;
            else if (w_start)
                r_busy <= 1'b1;
        end
    end

    assign bus.sda_oe = r_sda_oe;
    assign init_done  = r_init_done;
    assign rd_count   = r_rd_count;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_nunchuck_i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nunchuck_i2c_target
//  Description : Self-checking bench: bit-banged I2C initiator, vector table
//                and a queue of expected read bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nunchuck_i2c_target;

    localparam int c_Q = 16;   // clk cycles per quarter I2C bit

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] joy_x, joy_y;
    logic [9:0] acc_x, acc_y, acc_z;
    logic       btn_c, btn_z;
    logic       init_done;
    logic [7:0] rd_count;
    logic       busy;

    nunchuck_i2c_target_if bus ();

    nunchuck_i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .joy_x     (joy_x),
        .joy_y     (joy_y),
        .acc_x     (acc_x),
        .acc_y     (acc_y),
        .acc_z     (acc_z),
        .btn_c     (btn_c),
        .btn_z     (btn_z),
        .init_done (init_done),
        .rd_count  (rd_count),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         exp_rd_count = 0;
    logic [7:0] sb_q [$];
    bit         watch = 1'b0;
    int         drive_cnt = 0;

    always @(negedge clk) if (watch && bus.sda_oe) drive_cnt++;

    typedef struct packed {
        logic [7:0]      jx, jy;
        logic [9:0]      ax, ay, az;
        logic            c, z;
        logic [7:0]      ptr;
        int              n;
        bit              rep;
        logic [7:0][7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [7:0] jx, input logic [7:0] jy,
                                              input logic [9:0] ax, input logic [9:0] ay,
                                              input logic [9:0] az, input logic c,
                                              input logic z, input int p);
        case (p)
            0:       return jx;
            1:       return jy;
            2:       return ax[9:2];
            3:       return ay[9:2];
            4:       return az[9:2];
            5:       return {az[1:0], ay[1:0], ax[1:0], ~c, ~z};
            default: return 8'hFF;
        endcase
    endfunction

    function automatic vec_t make_vec(input logic [7:0] jx, input logic [7:0] jy,
                                      input logic [9:0] ax, input logic [9:0] ay,
                                      input logic [9:0] az, input logic c, input logic z,
                                      input logic [7:0] ptr, input int n, input bit rep);
        vec_t v;
        v.jx = jx; v.jy = jy; v.ax = ax; v.ay = ay; v.az = az;
        v.c = c; v.z = z; v.ptr = ptr; v.n = n; v.rep = rep;
        for (int k = 0; k < 8; k++)
            v.exp[k] = model_byte(jx, jy, ax, ay, az, c, z, int'(ptr) + k);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs;
        joy_x = 8'($urandom); joy_y = 8'($urandom);
        acc_x = 10'($urandom); acc_y = 10'($urandom); acc_z = 10'($urandom);
        btn_c = 1'($urandom); btn_z = 1'($urandom);
    endtask

    task automatic i2c_start;
        bus.sda_init = 1'b1; tick(c_Q);
        bus.scl      = 1'b1; tick(c_Q);
        bus.sda_init = 1'b0; tick(c_Q);
        bus.scl      = 1'b0; tick(c_Q);
    endtask

    task automatic i2c_stop;
        bus.sda_init = 1'b0; tick(c_Q);
        bus.scl      = 1'b1; tick(c_Q);
        bus.sda_init = 1'b1; tick(c_Q);
    endtask

    task automatic i2c_bit(input logic b, output logic s);
        bus.sda_init = b;    tick(c_Q);
        bus.scl      = 1'b1; tick(c_Q);
        s = bus.sda;         tick(c_Q);
        bus.scl      = 1'b0; tick(c_Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
        i2c_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            i2c_bit(1'b1, s);
            b = {b[6:0], s};
        end
        i2c_bit(~ack, s);
    endtask

    task automatic write_txn(input string name, input logic [7:0] p, input bit has_data,
                             input logic [7:0] d, input bit do_stop);
        logic ack;
        i2c_start;
        send_byte(8'hA4, ack); check({name, "_addr_ack"}, ack, 1);
        send_byte(p, ack);     check({name, "_ptr_ack"},  ack, 1);
        if (has_data) begin
            send_byte(d, ack); check({name, "_data_ack"}, ack, 1);
        end
        if (do_stop) i2c_stop;
    endtask

    task automatic read_txn(input string name, input int n);
        logic       ack;
        logic [7:0] b, e;
        i2c_start;
        send_byte(8'hA5, ack);
        check({name, "_rd_addr_ack"}, ack, 1);
        check({name, "_busy"}, busy, 1);
        for (int k = 0; k < n; k++) begin
            recv_byte(k != n - 1, b);
            randomize_inputs;   // must not affect the snapshot
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL %s_sb: got 0x%0h, expected queue entry (empty)", name, b);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("%s_byte%0d", name, k), b, e);
            end
        end
        i2c_stop;
        exp_rd_count++;
        check({name, "_rd_count"}, rd_count, 8'(exp_rd_count));
        check({name, "_busy_end"}, busy, 0);
    endtask

    initial begin
        vec_t       vecs [5];
        logic       ack, s;

        rst_n = 1'b0;
        bus.scl = 1'b1; bus.sda_init = 1'b1;
        joy_x = 8'h3C; joy_y = 8'hC3; acc_x = 10'h123; acc_y = 10'h2AB; acc_z = 10'h0F0;
        btn_c = 1'b0; btn_z = 1'b1;

        vecs[0] = make_vec(8'h80, 8'h7F, 10'h201, 10'h1FE, 10'h3FF, 1'b1, 1'b0, 8'h00, 6, 1'b0);
        vecs[1] = make_vec(8'h00, 8'hFF, 10'h000, 10'h3FF, 10'h155, 1'b0, 1'b1, 8'h00, 6, 1'b1);
        vecs[2] = make_vec(8'($urandom), 8'($urandom), 10'($urandom), 10'($urandom),
                           10'($urandom), 1'b1, 1'b1, 8'h02, 4, 1'b0);
        vecs[3] = make_vec(8'($urandom), 8'($urandom), 10'($urandom), 10'($urandom),
                           10'($urandom), 1'b0, 1'b0, 8'h04, 8, 1'b0);
        vecs[4] = make_vec(8'h5A, 8'hA5, 10'h2AA, 10'h155, 10'h0F0, 1'b1, 1'b1, 8'h05, 2, 1'b1);

        tick(5);
        check("rst_sda_oe",    bus.sda_oe, 0);
        check("rst_busy",      busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_rd_count",  rd_count, 0);
        rst_n = 1'b1;
        tick(10);

        // Read before init: served only when the init check is compiled out
`ifdef NUNCHUCK_TGT_INIT_CHECK_EN
        i2c_start;
        send_byte(8'hA5, ack);
        check("preinit_addr_nack", ack, 0);
        i2c_stop;
        check("preinit_rd_count", rd_count, 0);
`else
        sb_q.push_back(model_byte(joy_x, joy_y, acc_x, acc_y, acc_z, btn_c, btn_z, 0));
        read_txn("preinit", 1);
`endif

        write_txn("init_f0", 8'hF0, 1'b1, 8'h55, 1'b1);
        check("init_after_f0", init_done, 0);
        write_txn("init_fb", 8'hFB, 1'b1, 8'h00, 1'b1);
        check("init_after_fb", init_done, 1);

        // Foreign address 0x53: never ACKed, SDA never pulled
        drive_cnt = 0;
        watch = 1'b1;
        i2c_start;
        send_byte(8'hA6, ack);
        check("badaddr_nack", ack, 0);
        send_byte(8'h00, ack);
        check("badaddr_busy", busy, 1);
        i2c_stop;
        watch = 1'b0;
        check("badaddr_no_drive", drive_cnt, 0);
        check("badaddr_busy_end", busy, 0);

        for (int i = 0; i < 5; i++) begin
            joy_x = vecs[i].jx; joy_y = vecs[i].jy;
            acc_x = vecs[i].ax; acc_y = vecs[i].ay; acc_z = vecs[i].az;
            btn_c = vecs[i].c;  btn_z = vecs[i].z;
            write_txn($sformatf("v%0d_wr", i), vecs[i].ptr, 1'b0, 8'h00, !vecs[i].rep);
            for (int k = 0; k < vecs[i].n; k++) sb_q.push_back(vecs[i].exp[k]);
            read_txn($sformatf("v%0d", i), vecs[i].n);
        end

        // Reset in the middle of a byte that is driving SDA low
        joy_x = 8'h00;
        write_txn("rst_wr", 8'h00, 1'b0, 8'h00, 1'b1);
        i2c_start;
        send_byte(8'hA5, ack);
        check("rst_rd_ack", ack, 1);
        for (int i = 0; i < 3; i++) i2c_bit(1'b1, s);
        check("rst_pre_drive", bus.sda_oe, 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_sda_oe",    bus.sda_oe, 0);
        check("rst_mid_busy",      busy, 0);
        check("rst_mid_init_done", init_done, 0);
        check("rst_mid_rd_count",  rd_count, 0);
        bus.scl = 1'b1; bus.sda_init = 1'b1;
        tick(10);
        rst_n = 1'b1;
        tick(20);
        check("post_rst_busy", busy, 0);
        check("post_rst_sda_oe", bus.sda_oe, 0);
        check("post_rst_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
